// File: rtl/rf_mode_switch_ctrl.sv
// RF transceiver mode controller: synchronises and debounces the M-pins,
// commits a new mode only while idle and free, then holds AUX low for a
// per-transition settle time (long when leaving the configuration mode).
module rf_mode_switch_ctrl #(
  parameter int                MODE_W       = 2,
  parameter logic [MODE_W-1:0] DEFAULT_MODE = '1,
  parameter logic [MODE_W-1:0] CFG_MODE     = MODE_W'(3),
  parameter int                SYNC_STAGES  = 2,
  parameter int                DEBOUNCE_CYC = 4,
  parameter int                SETTLE_CYC   = 16,
  parameter int                RESET_CYC    = 10000,
  parameter int                POWERON_CYC  = 10000,
  parameter logic              AUX_POWER_ON = 1'b1
) (
  input  logic              internal_clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_pins,
  input  logic              aux_state_ctrl,
  input  logic              aux_uart_ctrl,
  output logic [MODE_W-1:0] mode_sync,
  output logic              aux_mode_ctrl,
  output logic              mode_changed,
  output logic              busy
);

  localparam int MAX_SR  = (SETTLE_CYC > RESET_CYC) ? SETTLE_CYC : RESET_CYC;
  localparam int MAX_CYC = (MAX_SR > POWERON_CYC) ? MAX_SR : POWERON_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  // SETTLE is unreachable when SETTLE_CYC is 0; keep its terminal count legal
  localparam int SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;

  typedef enum logic [1:0] {INIT, IDLE, SETTLE, RESET_WAIT} state_t;

  state_t                               state;
  logic [SYNC_STAGES-1:0][MODE_W-1:0]   sync_q;
  logic [MODE_W-1:0]                    req_s;
  logic [MODE_W-1:0]                    db_last;
  logic [MODE_W-1:0]                    req_stable;
  logic [DB_W-1:0]                      db_cnt;
  logic [DB_W-1:0]                      db_nxt;
  logic [CNT_W-1:0]                     cnt;
  logic [CNT_W-1:0]                     cnt_last;
  logic                                 done;
  logic                                 fire;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Input synchroniser: shift the raw pins through SYNC_STAGES flops
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{DEFAULT_MODE}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], mode_pins};
  end

  // Run length of identical synchronised samples, saturating at DEBOUNCE_CYC
  always_comb begin
    db_nxt = db_cnt;
    if (req_s != db_last)                  db_nxt = DB_W'(1);
    else if (db_cnt != DB_W'(DEBOUNCE_CYC)) db_nxt = db_cnt + 1'b1;
  end

  // Debouncer: accept a value once it has been seen DEBOUNCE_CYC times running
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      db_last    <= DEFAULT_MODE;
      db_cnt     <= '0;
      req_stable <= DEFAULT_MODE;
    end else begin
      db_last <= req_s;
      db_cnt  <= db_nxt;
      if (db_nxt == DB_W'(DEBOUNCE_CYC)) req_stable <= req_s;
    end
  end

  // Terminal count for the timed state currently occupied
  always_comb begin
    cnt_last = CNT_W'(POWERON_CYC - 1);
    case (state)
      SETTLE:     cnt_last = CNT_W'(SETTLE_LAST);
      RESET_WAIT: cnt_last = CNT_W'(RESET_CYC - 1);
      default:    cnt_last = CNT_W'(POWERON_CYC - 1);
    endcase
  end

  assign done = (cnt == cnt_last);
  assign fire = (state == IDLE) && (req_stable != mode_sync) &&
                aux_state_ctrl && aux_uart_ctrl;
  assign busy = (state != IDLE);

  // Mode FSM: power-on wait, commit of pending requests, AUX-low hold
  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      cnt           <= '0;
      mode_sync     <= DEFAULT_MODE;
      aux_mode_ctrl <= AUX_POWER_ON;
      mode_changed  <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      case (state)
        INIT: begin
          if (done) begin
            state         <= IDLE;
            cnt           <= '0;
            aux_mode_ctrl <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (fire) begin
            mode_sync    <= req_stable;
            mode_changed <= 1'b1;
            cnt          <= '0;
            // only leaving configuration mode needs the long reset time
            if (mode_sync == CFG_MODE && req_stable != CFG_MODE) begin
              aux_mode_ctrl <= 1'b0;
              state         <= RESET_WAIT;
            end else if (SETTLE_CYC > 0) begin
              aux_mode_ctrl <= 1'b0;
              state         <= SETTLE;
            end
          end
        end
        SETTLE, RESET_WAIT: begin
          if (done) begin
            aux_mode_ctrl <= 1'b1;
            state         <= IDLE;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_mode_switch_ctrl.md
# rf_mode_switch_ctrl

Second-generation mode controller for the RF transceiver. It samples the asynchronous mode-select pins, synchronises and debounces them, and commits a new operating mode only when the module is free. It then drives the AUX busy indication low for a per-transition settle time: a long reset time when leaving the configuration mode, a short settle time for any other change. It sits between the external M-pins and the transceiver's state, UART and AUX logic, and replaces the fixed 2-bit, single-delay controller.

## Interface
- MODE_W, 2: width of the mode-select bus.
- DEFAULT_MODE, all ones (3 for MODE_W=2): mode_sync value after reset.
- CFG_MODE, 3: configuration/stand-by mode; leaving it takes RESET_CYC.
- SYNC_STAGES, 2: flip-flop stages of the input synchroniser (≥2).
- DEBOUNCE_CYC, 4: consecutive equal synchronised samples required to accept a pin value (≥1).
- SETTLE_CYC, 16: AUX-low time for an ordinary mode change; 0 = no AUX drop.
- RESET_CYC, 10000: AUX-low time when leaving CFG_MODE (≥1).
- POWERON_CYC, 10000: INIT duration after reset (≥1).
- AUX_POWER_ON, 1'b1: aux_mode_ctrl value during reset and INIT.

Ports:
- internal_clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode_pins  in  MODE_W  asynchronous mode request ({M1,M0} for MODE_W=2).
- aux_state_ctrl  in  1  high = transceiver state logic idle.
- aux_uart_ctrl  in  1  high = UART logic idle.
- mode_sync  out  MODE_W  committed operating mode (registered).
- aux_mode_ctrl  out  1  mode-controller contribution to AUX (registered; 0 = busy).
- mode_changed  out  1  one-cycle pulse on the edge mode_sync updates.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- Reset values: mode_sync=DEFAULT_MODE, aux_mode_ctrl=AUX_POWER_ON, mode_changed=0, busy=1, state=INIT, synchroniser and debounce registers=DEFAULT_MODE, counters=0.
- Input path: mode_pins → SYNC_STAGES flops → req_s. The debouncer accepts req_s into req_stable after DEBOUNCE_CYC consecutive identical samples. Any change restarts the count.
- Counter width is $clog2(max(SETTLE_CYC,RESET_CYC,POWERON_CYC)+1). It counts 0..N-1, then asserts done. It is cleared on every state entry.
- INIT: aux_mode_ctrl=AUX_POWER_ON for POWERON_CYC cycles, then IDLE with aux_mode_ctrl=1. Requests are ignored during INIT; req_stable is still tracked.
- IDLE: a switch fires when req_stable≠mode_sync AND aux_state_ctrl AND aux_uart_ctrl. On that edge:
  - mode_sync←req_stable.
  - mode_changed=1.
  - If the old mode_sync==CFG_MODE and req_stable≠CFG_MODE: aux_mode_ctrl←0, go to RESET_WAIT.
  - Otherwise, if SETTLE_CYC>0: aux_mode_ctrl←0, go to SETTLE. If SETTLE_CYC==0: stay in IDLE with aux_mode_ctrl=1.
- If either idle input is low, the request stays pending. It fires on the first edge where both are high, using the req_stable value at that edge.
- SETTLE / RESET_WAIT: hold aux_mode_ctrl=0 for SETTLE_CYC / RESET_CYC cycles. On done: aux_mode_ctrl←1 and go to IDLE.
  - Pin changes during these states update req_stable only; they are not committed until IDLE.
  - On return to IDLE, a pending request is evaluated on the next edge. No back-to-back switch occurs on the done edge.
- Entering CFG_MODE uses SETTLE, not RESET_WAIT. A request equal to mode_sync does nothing.
- rst_n low at any time, including mid-switch, forces the reset values immediately. After release, the block restarts in INIT.

## Timing
- Pin change to req_stable: SYNC_STAGES+DEBOUNCE_CYC cycles. One more cycle to mode_sync when the block is idle and free.
- aux_mode_ctrl falls on the same edge as the mode_sync update. It is low for exactly SETTLE_CYC or RESET_CYC cycles.
- mode_changed is high for exactly one cycle, coincident with the new mode_sync.
- busy rises with the AUX drop and falls on the edge aux_mode_ctrl returns to 1.
- A glitch shorter than DEBOUNCE_CYC synchronised cycles produces no output change.

## Test plan
Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYC=4, SETTLE_CYC=8, RESET_CYC=20, POWERON_CYC=10, DEFAULT_MODE=3.
- Reset release → aux_mode_ctrl=1, busy=1 for 10 cycles; mode_sync=3 throughout; then busy=0.
- After INIT, pins 3→0 with both idle inputs high → mode_sync=0 and mode_changed pulse 7 cycles after the pin edge. aux_mode_ctrl low for 20 cycles.
- From mode 0, pins→2 → mode_sync=2, aux_mode_ctrl low for 8 cycles. Then pins→3 → aux_mode_ctrl low for 8 cycles, not 20.
- Pins pulse 0→1→0 for 3 cycles → no mode_sync change, no mode_changed pulse.
- Hold aux_uart_ctrl=0, pins→1 → mode_sync unchanged. Raise aux_uart_ctrl → mode_sync=1 on the next edge.
- Pins change to 2 at cycle 5 of a RESET_WAIT → committed only after that RESET_WAIT ends. Assert rst_n low during the resulting SETTLE → mode_sync=3, aux_mode_ctrl=1, state INIT immediately.
